imm_seq_ctrl: RTL and testbench

IMM_SEQ_CTRL -- requirements
Module: imm_seq_ctrl

---
 rtl/imm_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_imm_seq_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/imm_seq_ctrl.sv
// imm_seq_ctrl: ID->EX immediate sequencer. Selects sign/zero extension for the
// 6-bit immediate and registers the immediate into EX. With IMM_PREFIX_EN
// defined, an immediate-prefix opcode (PREFIX_OPC) supplies the upper 10 bits
// of a full 16-bit immediate for the next instruction.
// Optional feature macro: IMM_PREFIX_EN (undefined = prefix support removed).
module imm_seq_ctrl #(
  parameter logic [3:0]  PREFIX_OPC = 4'hF,
  parameter logic [15:0] ZEXT_MASK  = 16'h000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] ext_in,
  output logic        ext_ctrl,
  output logic [15:0] imm_out,
  output logic        imm_valid,
  output logic        prefix_pending,
  output logic        prefix_err
);

  logic [3:0]  opc;
  logic [15:0] imm_nxt;
  logic        vld_nxt;

  assign opc = instr[15:12];

  // Extender control depends only on the opcode, never on pipeline state.
  assign ext_ctrl = ~ZEXT_MASK[opc];

`ifdef IMM_PREFIX_EN
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [9:0]  payload, payload_nxt;
  logic        err_nxt;
  logic        unused_bits;

  assign unused_bits = ^instr[11:10];

  // State, payload and registered outputs; reset beats flush/stall/valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      payload    <= 10'h000;
      imm_out    <= 16'h0000;
      imm_valid  <= 1'b0;
      prefix_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      payload    <= payload_nxt;
      imm_out    <= imm_nxt;
      imm_valid  <= vld_nxt;
      prefix_err <= err_nxt;
    end
  end

  // Next-state and next-output decode; flush wins over stall and valid.
  always_comb begin
    state_nxt   = state;
    payload_nxt = payload;
    imm_nxt     = imm_out;
    vld_nxt     = imm_valid;
    err_nxt     = 1'b0;
    if (flush) begin
      state_nxt   = IDLE;
      payload_nxt = 10'h000;
      vld_nxt     = 1'b0;
    end else if (stall) begin
      // hold everything; error pulse drops
    end else if (instr_valid) begin
      if (opc == PREFIX_OPC) begin
        // later prefix wins; back-to-back prefixes flag an error
        err_nxt     = (state == HELD);
        payload_nxt = instr[9:0];
        state_nxt   = HELD;
        vld_nxt     = 1'b0;
      end else begin
        vld_nxt   = 1'b1;
        imm_nxt   = (state == HELD) ? {payload, instr[5:0]} : ext_in;
        state_nxt = IDLE;
      end
    end else begin
      vld_nxt = 1'b0;
    end
  end

  assign prefix_pending = (state == HELD);

`else
  logic unused_bits;

  assign unused_bits = ^instr[11:0];

  // Registered immediate path; every opcode takes the extender result.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_out   <= 16'h0000;
      imm_valid <= 1'b0;
    end else begin
      imm_out   <= imm_nxt;
      imm_valid <= vld_nxt;
    end
  end

  // Next-output decode: flush clears, stall holds, idle slot drops valid.
  always_comb begin
    imm_nxt = imm_out;
    vld_nxt = imm_valid;
    if (flush) begin
      vld_nxt = 1'b0;
    end else if (stall) begin
      // hold
    end else if (instr_valid) begin
      vld_nxt = 1'b1;
      imm_nxt = ext_in;
    end else begin
      vld_nxt = 1'b0;
    end
  end

  assign prefix_pending = 1'b0;
  assign prefix_err     = 1'b0;
`endif

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Scoreboard bench for imm_seq_ctrl: expected immediates are queued when an
// issuing instruction is driven and compared when the cycle completes.
module tb_imm_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, instr_valid, stall, flush;
  logic [15:0] instr, ext_in;
  logic        ext_ctrl, imm_valid, prefix_pending, prefix_err;
  logic [15:0] imm_out;

  localparam logic [15:0] ZMASK = 16'h000C;
`ifdef IMM_PREFIX_EN
  localparam bit PFX_EN = 1'b1;
`else
  localparam bit PFX_EN = 1'b0;
`endif

  imm_seq_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .ext_in(ext_in), .ext_ctrl(ext_ctrl),
    .imm_out(imm_out), .imm_valid(imm_valid),
    .prefix_pending(prefix_pending), .prefix_err(prefix_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference model state
  logic        m_held, m_vld, m_err;
  logic [9:0]  m_pay;
  logic [15:0] m_imm;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive on negedge, update model, check #1 after posedge.
  task automatic cyc(input logic [15:0] i, input logic v, input logic s,
                     input logic f, input logic r, input logic [15:0] e);
    logic issued;
    logic [3:0] op;
    logic [15:0] zm;
    @(negedge clk);
    instr = i; instr_valid = v; stall = s; flush = f; reset = r; ext_in = e;
    op = i[15:12];
    zm = ZMASK;
    #1 chk("ext_ctrl", {31'd0, ext_ctrl}, {31'd0, ~zm[op]});
    issued = 1'b0;
    if (r) begin
      m_held = 0; m_pay = 0; m_imm = 0; m_vld = 0; m_err = 0;
      sb.delete();
    end else if (f) begin
      m_held = 0; m_pay = 0; m_vld = 0; m_err = 0;
    end else if (s) begin
      m_err = 0;
    end else if (v) begin
      if (PFX_EN && op == 4'hF) begin
        m_err = m_held; m_pay = i[9:0]; m_held = 1; m_vld = 0;
      end else begin
        m_imm = m_held ? {m_pay, i[5:0]} : e;
        m_held = 0; m_vld = 1; m_err = 0; issued = 1'b1;
        sb.push_back(m_imm);
      end
    end else begin
      m_vld = 0; m_err = 0;
    end
    @(posedge clk);
    #1;
    chk("imm_valid", {31'd0, imm_valid}, {31'd0, m_vld});
    chk("prefix_pending", {31'd0, prefix_pending}, {31'd0, m_held});
    chk("prefix_err", {31'd0, prefix_err}, {31'd0, m_err});
    if (issued) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else chk("imm_out", {16'd0, imm_out}, {16'd0, sb.pop_front()});
    end else begin
      chk("imm_hold", {16'd0, imm_out}, {16'd0, m_imm});
    end
  endtask

  initial begin
    logic [15:0] ops[6];
    ops[0] = 16'h2000; ops[1] = 16'h3000; ops[2] = 16'h4000;
    ops[3] = 16'hF000; ops[4] = 16'h1000; ops[5] = 16'hF000;
    instr = 0; instr_valid = 0; stall = 0; flush = 0; reset = 1; ext_in = 0;
    m_held = 0; m_pay = 0; m_imm = 0; m_vld = 0; m_err = 0;

    // reset, then explicit reset-state checks
    cyc(16'h0000, 0, 0, 0, 1, 16'h0000);
    chk("rst_imm", {16'd0, imm_out}, 32'h0);
    chk("rst_vld", {31'd0, imm_valid}, 32'h0);

    // ANDI zero-extend, ADDI sign-extend
    cyc(16'h2015, 1, 0, 0, 0, 16'h0015);
    cyc(16'h4030, 1, 0, 0, 0, 16'hFFF0);
    cyc(16'h0000, 0, 0, 0, 0, 16'h1111);

    // prefix + consumer
    cyc(16'hF2AB, 1, 0, 0, 0, 16'h1234);
    cyc(16'h4025, 1, 0, 0, 0, 16'h5555);
    if (PFX_EN) chk("pfx_combine", {16'd0, imm_out}, 32'h0000AAE5);

    // prefix after prefix, later wins
    cyc(16'hF001, 1, 0, 0, 0, 16'h0000);
    cyc(16'hF3FF, 1, 0, 0, 0, 16'h0000);
    cyc(16'h403F, 1, 0, 0, 0, 16'h0000);
    if (PFX_EN) chk("pfx_later_wins", {16'd0, imm_out}, 32'h0000FFFF);

    // prefix, stall 3 cycles, flush (with stall), fresh ADDI
    cyc(16'hF155, 1, 0, 0, 0, 16'h0000);
    repeat (3) cyc(16'h4001, 1, 1, 0, 0, 16'h7777);
    cyc(16'h4001, 1, 1, 1, 0, 16'h7777);
    cyc(16'h4001, 1, 0, 0, 0, 16'h0001);
    chk("post_flush", {16'd0, imm_out}, 32'h00000001);

    // stall while an immediate is valid, then an idle slot
    cyc(16'h3002, 1, 0, 0, 0, 16'h0002);
    cyc(16'h4003, 1, 1, 0, 0, 16'hAAAA);
    cyc(16'h4003, 0, 0, 0, 0, 16'hAAAA);

    // reset while HELD with stall
    cyc(16'hF0AA, 1, 0, 0, 0, 16'h0000);
    cyc(16'h4001, 1, 1, 0, 1, 16'h9999);
    chk("rst_held_imm", {16'd0, imm_out}, 32'h0);
    cyc(16'hF03C, 1, 0, 0, 0, 16'hFFCC);
    if (!PFX_EN) chk("nopfx_F03C", {16'd0, imm_out}, 32'h0000FFCC);

    // random mix
    for (int k = 0; k < 40; k++) begin
      logic [15:0] ins;
      ins = ops[$urandom_range(0, 5)] | 16'($urandom_range(0, 4095));
      cyc(ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 9) == 0), 1'b0, 16'($urandom));
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
